// File: rtl/logic_sweep_pkg.sv
// Shared definitions for the LogicCircuit sweep sequencer: state encoding,
// table geometry and the table slice helper.
package logic_sweep_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SETTLE = ST_SETTLE,
        SAMPLE = ST_SAMPLE,
        DONE   = ST_DONE
    } state_t;

    localparam int unsigned NUM_VEC = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned OUT_W   = 2;
    localparam int unsigned TBL_W   = NUM_VEC * OUT_W;
    localparam int unsigned OFF_W   = $clog2(TBL_W);

    // Bit offset of the {F1,F2} pair belonging to vector idx.
    function automatic logic [OFF_W-1:0] slice_off(input logic [IDX_W-1:0] idx);
        return {idx, 1'b0};
    endfunction

endpackage

// File: rtl/logic_sweep_ctrl_if.sv
// Control, status and datapath connections of the sweep sequencer.
// master = caller/datapath side, slave = the sequencer.
interface logic_sweep_ctrl_if;
    import logic_sweep_pkg::*;

    logic              start;
    logic              abort;
    logic [TBL_W-1:0]  exp_table;
    logic [OUT_W-1:0]  f_in;
    logic [IDX_W-1:0]  vec_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [TBL_W-1:0]  result_table;
    logic [CNT_W-1:0]  mismatch_cnt;
    logic              fail_valid;
    logic [IDX_W-1:0]  first_fail_idx;

    modport master (
        output start, abort, exp_table, f_in,
        input  vec_out, busy, done, pass, result_table, mismatch_cnt,
               fail_valid, first_fail_idx
    );

    modport slave (
        input  start, abort, exp_table, f_in,
        output vec_out, busy, done, pass, result_table, mismatch_cnt,
               fail_valid, first_fail_idx
    );

endinterface

// File: rtl/logic_sweep_settle_timer.sv
// Loadable down-counter that measures the settle window of one vector.
// expired is high once SETTLE_CYCLES-1 decrements have elapsed after load.
module logic_sweep_settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/logic_sweep_ctrl.sv
// Sweeps the 4-input LogicCircuit through all 16 vectors, captures {F1,F2}
// after a settle window and scores the captures against a latched table.
module logic_sweep_ctrl
    import logic_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    logic_sweep_ctrl_if.slave  bus
);
    // With no settle window every vector goes straight to its sample cycle.
    localparam state_t ENTRY_ST = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, vec_q, first_q;
    logic [TBL_W-1:0]  exp_q, result_q;
    logic [CNT_W-1:0]  mism_q;
    logic              fail_q, pass_q;

    logic accept, do_sample, abort_hit, timer_load, timer_en, timer_expired, last_vec;

    assign last_vec = (idx_q == IDX_W'(NUM_VEC - 1));
    assign timer_en = (state_q == SETTLE);

    generate
        if (SETTLE_CYCLES == 0) begin : g_no_timer
            logic unused_timer;
            assign unused_timer  = timer_load ^ timer_en;
            assign timer_expired = 1'b1;
        end else begin : g_timer
            logic_sweep_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (timer_load),
                .en      (timer_en),
                .expired (timer_expired)
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        do_sample  = 1'b0;
        abort_hit  = 1'b0;
        timer_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    accept     = 1'b1;
                    timer_load = 1'b1;
                    state_d    = ENTRY_ST;
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    abort_hit = 1'b1;
                    state_d   = IDLE;
                end else if (timer_expired) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (bus.abort) begin
                    abort_hit = 1'b1;
                    state_d   = IDLE;
                end else begin
                    do_sample = 1'b1;
                    if (last_vec) begin
                        state_d = DONE;
                    end else begin
                        timer_load = 1'b1;
                        state_d    = ENTRY_ST;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            vec_q    <= '0;
            first_q  <= '0;
            exp_q    <= '0;
            result_q <= '0;
            mism_q   <= '0;
            fail_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else if (accept) begin
            idx_q    <= '0;
            vec_q    <= '0;
            first_q  <= '0;
            exp_q    <= bus.exp_table;
            result_q <= '0;
            mism_q   <= '0;
            fail_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else if (do_sample) begin
            result_q[slice_off(idx_q) +: OUT_W] <= bus.f_in;
            if (bus.f_in != exp_q[slice_off(idx_q) +: OUT_W]) begin
                mism_q <= mism_q + CNT_W'(1);
                if (!fail_q) begin
                    first_q <= idx_q;
                    fail_q  <= 1'b1;
                end
            end
            if (!last_vec) begin
                idx_q <= idx_q + IDX_W'(1);
                vec_q <= idx_q + IDX_W'(1);
            end
        end else if (state_q == DONE) begin
            pass_q <= (mism_q == '0);
            vec_q  <= '0;
        end else if (abort_hit) begin
            vec_q <= '0;
        end
    end

    assign bus.vec_out        = vec_q;
    assign bus.busy           = (state_q == SETTLE) || (state_q == SAMPLE);
    assign bus.done           = (state_q == DONE);
    assign bus.pass           = pass_q;
    assign bus.result_table   = result_q;
    assign bus.mismatch_cnt   = mism_q;
    assign bus.fail_valid     = fail_q;
    assign bus.first_fail_idx = first_q;

endmodule
